// File: rtl/mul_div_unit_pkg.sv
// ---------------------------------------------------------------------------
// mul_div_unit_pkg
// Shared definitions for the RV32M multiply/divide unit:
//   - ALU operation codes (the M-extension group plus ADD, which the unit
//     must ignore),
//   - MDU state encodings,
//   - the iteration count and an opcode-group helper.
// ---------------------------------------------------------------------------
package mul_div_unit_pkg;

    localparam int MDU_XLEN        = 32;
    localparam int MDU_CALC_CYCLES = 32;

    // ALU operation codes. The M-extension codes are contiguous so that
    // membership in the MUL..REMU group is a simple range check.
    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_MUL    = 5'd16;
    localparam logic [4:0] ALU_MULH   = 5'd17;
    localparam logic [4:0] ALU_MULHSU = 5'd18;
    localparam logic [4:0] ALU_MULHU  = 5'd19;
    localparam logic [4:0] ALU_DIV    = 5'd20;
    localparam logic [4:0] ALU_DIVU   = 5'd21;
    localparam logic [4:0] ALU_REM    = 5'd22;
    localparam logic [4:0] ALU_REMU   = 5'd23;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } mdu_state_e;

    function automatic logic is_mdu_op(input logic [4:0] code);
        return (code >= ALU_MUL) && (code <= ALU_REMU);
    endfunction

endpackage

// File: rtl/mul_div_unit_iter_core.sv
// ---------------------------------------------------------------------------
// mdu_iter_core
// Unsigned one-bit-per-cycle iteration engine shared by multiply and divide.
//   clk, reset     : clock, synchronous active-high reset
//   load           : load accumulator = {0, load_lo}, operand = load_operand,
//                    clear the iteration counter
//   step           : perform one iteration in the selected mode
//   mode_div       : 0 = shift-add multiply, 1 = restoring divide
//   load_lo        : multiplier (mul) or dividend (div) magnitude
//   load_operand   : multiplicand (mul) or divisor (div) magnitude
//   acc            : 64-bit accumulator; mul -> product,
//                    div -> {remainder, quotient}
//   last           : high while the final iteration is being stepped
// ---------------------------------------------------------------------------
module mdu_iter_core
    import mul_div_unit_pkg::*;
#(
    parameter int XLEN        = MDU_XLEN,
    parameter int CALC_CYCLES = MDU_CALC_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic              mode_div,
    input  logic [XLEN-1:0]   load_lo,
    input  logic [XLEN-1:0]   load_operand,
    output logic [2*XLEN-1:0] acc,
    output logic              last
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   operand_q;
    logic [5:0]        count_q;
    logic [XLEN:0]     mul_sum;
    logic [XLEN+1:0]   div_diff;

    // NOTE: every variable assigned here gets a value on every path, so no
    // latch is inferred; keep it that way when adding modes.
    always_comb begin
        // Multiply: conditionally add the multiplicand into the upper half,
        // then shift the 33-bit sum and the remaining multiplier bits right.
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]}
                 + (acc_q[0] ? {1'b0, operand_q} : {(XLEN+1){1'b0}});
        // Divide: trial-subtract the divisor from the partial remainder as it
        // would be after the left shift (33 bits, as the top bit shifts out).
        div_diff = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, operand_q};

        if (mode_div) begin
            if (div_diff[XLEN+1]) begin
                acc_d = {acc_q[2*XLEN-2:0], 1'b0};
            end else begin
                acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            operand_q <= '0;
            count_q   <= '0;
        end else if (load) begin
            acc_q     <= {{XLEN{1'b0}}, load_lo};
            operand_q <= load_operand;
            count_q   <= '0;
        end else if (step) begin
            acc_q     <= acc_d;
            count_q   <= count_q + 6'd1;
        end
    end

    assign acc  = acc_q;
    assign last = (count_q == 6'(CALC_CYCLES - 1));

endmodule

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
// Multi-cycle RV32M execution unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
// sitting in the E stage. It requests a pipeline stall while an operation is
// in flight and releases it in the cycle its result is valid.
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset
//   start     : operation request, sampled at the rising edge
//   alucode   : operation code (mul_div_unit_pkg ALU_*)
//   op1, op2  : rs1 / rs2 values
//   stall_req : combinational; high on an accepted start or in CALC/FIXUP
//   busy      : registered; high in CALC or FIXUP
//   done      : registered one-cycle pulse, result valid
//   result    : registered result, held until the next FIXUP or reset
// ---------------------------------------------------------------------------
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int XLEN        = MDU_XLEN,
    parameter int CALC_CYCLES = MDU_CALC_CYCLES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [4:0]      alucode,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            stall_req,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    mdu_state_e        state_q, state_d;
    logic [4:0]        op_q;
    logic              neg_q;        // product/quotient needs negation
    logic              neg_rem_q;    // remainder takes a negative dividend's sign
    logic              early_q;      // result is early_res_q, skip iteration
    logic [XLEN-1:0]   early_res_q;
    logic [XLEN-1:0]   result_q, result_d;
    logic              busy_q, done_q;

    logic              accept;
    logic              a_signed, b_signed, a_neg, b_neg;
    logic              is_div, div_zero, overflow, early;
    logic [XLEN-1:0]   early_val, mag_a, mag_b;
    logic              step, core_last;
    logic [2*XLEN-1:0] acc, prod;
    logic [XLEN-1:0]   quot, rem, fix_val;

    // Reset has priority over a same-cycle start, so it never raises a stall.
    assign accept = start && !reset && is_mdu_op(alucode)
                 && ((state_q == IDLE) || (state_q == DONE));

    // Accept-time operand decode: signedness, magnitudes and early-out cases.
    always_comb begin
        a_signed  = (alucode == ALU_MULH) || (alucode == ALU_MULHSU)
                 || (alucode == ALU_DIV)  || (alucode == ALU_REM);
        b_signed  = (alucode == ALU_MULH) || (alucode == ALU_DIV)
                 || (alucode == ALU_REM);
        a_neg     = a_signed && op1[XLEN-1];
        b_neg     = b_signed && op2[XLEN-1];
        mag_a     = a_neg ? -op1 : op1;
        mag_b     = b_neg ? -op2 : op2;

        is_div    = (alucode == ALU_DIV) || (alucode == ALU_DIVU)
                 || (alucode == ALU_REM) || (alucode == ALU_REMU);
        div_zero  = is_div && (op2 == '0);
        overflow  = ((alucode == ALU_DIV) || (alucode == ALU_REM))
                 && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
        early     = div_zero || overflow;

        early_val = '0;
        if (div_zero) begin
            early_val = ((alucode == ALU_DIV) || (alucode == ALU_DIVU)) ? '1 : op1;
        end else if (overflow && (alucode == ALU_DIV)) begin
            early_val = {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    mdu_iter_core #(
        .XLEN        (XLEN),
        .CALC_CYCLES (CALC_CYCLES)
    ) u_core (
        .clk          (clk),
        .reset        (reset),
        .load         (accept),
        .step         (step),
        .mode_div     (op_q >= ALU_DIV),
        .load_lo      (mag_a),
        .load_operand (mag_b),
        .acc          (acc),
        .last         (core_last)
    );

    // Sign correction and result selection, used in FIXUP.
    always_comb begin
        prod = neg_q ? -acc : acc;
        quot = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg_rem_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op_q)
            ALU_MUL:                          fix_val = prod[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU:  fix_val = prod[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:                fix_val = quot;
            default:                          fix_val = rem;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        step     = 1'b0;
        result_d = result_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = early ? FIXUP : CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                step = 1'b1;
                if (core_last) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                state_d  = DONE;
                result_d = early_q ? early_res_q : fix_val;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            neg_q       <= 1'b0;
            neg_rem_q   <= 1'b0;
            early_q     <= 1'b0;
            early_res_q <= '0;
            result_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            busy_q   <= (state_d == CALC) || (state_d == FIXUP);
            done_q   <= (state_d == DONE);
            if (accept) begin
                op_q        <= alucode;
                neg_q       <= a_neg ^ b_neg;
                neg_rem_q   <= a_neg;
                early_q     <= early;
                early_res_q <= early_val;
            end
        end
    end

    assign stall_req = accept || (state_q == CALC) || (state_q == FIXUP);
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
// Directed bench for mul_div_unit. Inputs change at the falling edge and
// outputs are sampled 1 ns after it, well away from the rising edge.
// Cycle c = 0 is the cycle in which start is presented.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  alucode = ALU_ADD;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        stall_req, busy, done;
    logic [31:0] result;

    int n_vec  = 0;
    int n_miss = 0;

    mul_div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .alucode   (alucode),
        .op1       (op1),
        .op2       (op2),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Runs one operation from IDLE and checks stall_req/busy/done every cycle
    // and the result in the done cycle. Operands and alucode are scrambled
    // after the start cycle to show they were latched.
    task automatic apply_op(input logic [4:0] code, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp,
                            input bit early, input string tag);
        int done_c;
        logic e_stall, e_busy, e_done;
        done_c = early ? 2 : 34;
        @(negedge clk);
        start = 1'b1; alucode = code; op1 = a; op2 = b;
        for (int c = 0; c <= done_c + 2; c++) begin
            #1;
            e_stall = (c < done_c);
            e_busy  = (c >= 1) && (c < done_c);
            e_done  = (c == done_c);
            n_vec++;
            if (stall_req !== e_stall) begin
                n_miss++;
                $display("FAIL %s c%0d stall_req got %b want %b", tag, c, stall_req, e_stall);
            end
            n_vec++;
            if (busy !== e_busy) begin
                n_miss++;
                $display("FAIL %s c%0d busy got %b want %b", tag, c, busy, e_busy);
            end
            n_vec++;
            if (done !== e_done) begin
                n_miss++;
                $display("FAIL %s c%0d done got %b want %b", tag, c, done, e_done);
            end
            if (c == done_c) begin
                n_vec++;
                if (result !== exp) begin
                    n_miss++;
                    $display("FAIL %s result got %h want %h", tag, result, exp);
                end
            end
            @(negedge clk);
            if (c == 0) begin
                start = 1'b0; alucode = ALU_DIVU; op1 = ~a; op2 = a ^ b ^ 32'h1;
            end
        end
    endtask

    task automatic test_reset();
        // Reset asserted together with a valid start: reset must win.
        @(negedge clk);
        reset = 1'b1; start = 1'b1; alucode = ALU_MUL; op1 = 32'd9; op2 = 32'd9;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0) begin n_miss++; $display("FAIL reset busy got %b want 0", busy); end
        n_vec++;
        if (done !== 1'b0) begin n_miss++; $display("FAIL reset done got %b want 0", done); end
        n_vec++;
        if (stall_req !== 1'b0) begin n_miss++; $display("FAIL reset stall_req got %b want 0", stall_req); end
        n_vec++;
        if (result !== 32'h0) begin n_miss++; $display("FAIL reset result got %h want 0", result); end
    endtask

    task automatic test_mul();
        apply_op(ALU_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul_7xm3");
    endtask

    task automatic test_mulh();
        apply_op(ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "mulhu");
        apply_op(ALU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "mulh");
        apply_op(ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhsu");
    endtask

    task automatic test_div();
        apply_op(ALU_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, "div_m7_2");
        apply_op(ALU_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, "rem_m7_2");
        apply_op(ALU_DIVU, 32'd7, 32'd2, 32'd3, 1'b0, "divu_7_2");
        apply_op(ALU_REMU, 32'd7, 32'd2, 32'd1, 1'b0, "remu_7_2");
    endtask

    task automatic test_early_out();
        apply_op(ALU_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, "div_by0");
        apply_op(ALU_REMU, 32'd5, 32'd0, 32'd5, 1'b1, "remu_by0");
        apply_op(ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_ovf");
        apply_op(ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "rem_ovf");
    endtask

    task automatic test_reset_calc();
        @(negedge clk);
        start = 1'b1; alucode = ALU_MUL; op1 = 32'd5; op2 = 32'd6;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;                      // asserted during cycle k+10
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0) begin n_miss++; $display("FAIL rst_calc busy got %b want 0", busy); end
        n_vec++;
        if (stall_req !== 1'b0) begin n_miss++; $display("FAIL rst_calc stall_req got %b want 0", stall_req); end
        n_vec++;
        if (result !== 32'h0) begin n_miss++; $display("FAIL rst_calc result got %h want 0", result); end
        for (int c = 0; c < 30; c++) begin
            n_vec++;
            if (done !== 1'b0) begin n_miss++; $display("FAIL rst_calc done pulse at +%0d", c); end
            @(negedge clk);
            #1;
        end
        apply_op(ALU_MUL, 32'd3, 32'd4, 32'd12, 1'b0, "mul_after_rst");
    endtask

    task automatic test_start_ignored();
        // MUL 6*7 with an M-op start poked in during CALC.
        @(negedge clk);
        start = 1'b1; alucode = ALU_MUL; op1 = 32'd6; op2 = 32'd7;
        for (int c = 0; c <= 34; c++) begin
            #1;
            if (c >= 1 && c <= 33) begin
                n_vec++;
                if (stall_req !== 1'b1) begin n_miss++; $display("FAIL ign_start c%0d stall_req got %b want 1", c, stall_req); end
            end
            if (c == 33) begin
                n_vec++;
                if (done !== 1'b0) begin n_miss++; $display("FAIL ign_start early done got %b want 0", done); end
            end
            if (c == 34) begin
                n_vec++;
                if (done !== 1'b1) begin n_miss++; $display("FAIL ign_start done got %b want 1", done); end
                n_vec++;
                if (result !== 32'd42) begin n_miss++; $display("FAIL ign_start result got %h want %h", result, 32'd42); end
            end
            @(negedge clk);
            start = (c == 4);
            if (c == 4) begin alucode = ALU_DIVU; op1 = 32'd100; op2 = 32'd7; end
        end
        // Start with a non-M alucode: no stall, no activity.
        start = 1'b1; alucode = ALU_ADD; op1 = 32'd1; op2 = 32'd2;
        #1;
        n_vec++;
        if (stall_req !== 1'b0) begin n_miss++; $display("FAIL add_start stall_req got %b want 0", stall_req); end
        @(negedge clk);
        start = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0) begin n_miss++; $display("FAIL add_start busy got %b want 0", busy); end
        n_vec++;
        if (result !== 32'd42) begin n_miss++; $display("FAIL add_start result got %h want %h", result, 32'd42); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        start = 1'b1; alucode = ALU_MUL; op1 = 32'd5; op2 = 32'd5;
        for (int c = 0; c <= 34; c++) begin
            #1;
            if (c == 34) begin
                n_vec++;
                if (done !== 1'b1) begin n_miss++; $display("FAIL b2b first done got %b want 1", done); end
                n_vec++;
                if (result !== 32'd25) begin n_miss++; $display("FAIL b2b first result got %h want %h", result, 32'd25); end
                start = 1'b1; alucode = ALU_DIVU; op1 = 32'd100; op2 = 32'd7;
                #1;
                n_vec++;
                if (stall_req !== 1'b1) begin n_miss++; $display("FAIL b2b accept stall_req got %b want 1", stall_req); end
            end
            @(negedge clk);
            if (c == 0 || c == 34) start = 1'b0;
        end
        // Second op began in cycle 34; d counts cycles from there.
        for (int d = 1; d <= 35; d++) begin
            #1;
            n_vec++;
            if (done !== (d == 34)) begin n_miss++; $display("FAIL b2b d%0d done got %b want %b", d, done, (d == 34)); end
            n_vec++;
            if (result !== ((d < 34) ? 32'd25 : 32'd14)) begin
                n_miss++;
                $display("FAIL b2b d%0d result got %h want %h", d, result, ((d < 34) ? 32'd25 : 32'd14));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_early_out();
        test_reset_calc();
        test_start_ignored();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
